// File: rtl/uart_rx.sv
// uart_rx: memory-mapped UART receiver (start, 8 data LSB first, parity, 1/2 stop).
// Ports: clk, reset (async low), addr/wr_data/wr_en/rd_en/rd_data bus, Rx_in, rx_valid. Option: UART_RX_SYNC_EN.
module uart_rx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] DATA_ADDR  = 32'h10,
  parameter logic [31:0] BAUD_ADDR  = 32'h14,
  parameter logic [31:0] CTRL_ADDR  = 32'h18,
  parameter logic [31:0] STAT_ADDR  = 32'h1C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  input  logic        Rx_in,
  output logic        rx_valid
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t state, state_nx;

  logic [13:0]   baud_div;
  logic          rx_en_r, two_stop_r, odd_par_r;
  logic [13:0]   cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          pe_pending, stop_bad;
  logic          frame_err, parity_err, overrun;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          rx_s;

  logic baud_eq, half_eq;
  logic frm_start, shift_en, par_chk, stop1_smp, done;
  logic full, empty, pop, push, stat_rd;
  logic stop_ok, frame_ok, exp_par;
  logic [3:0] cnt4;
  logic unused;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], Rx_in};
  end
  assign rx_s = sync[1];
`else
  assign rx_s = Rx_in;
`endif

  assign unused  = ^{wr_data[31:14]};
  assign baud_eq = cnt == baud_div;
  assign half_eq = cnt == (baud_div >> 1);
  assign full    = fifo_count == CW'(FIFO_DEPTH);
  assign empty   = fifo_count == '0;
  assign cnt4    = 4'(fifo_count);
  assign rx_valid = !empty;
  assign pop     = rd_en && addr == DATA_ADDR && !empty;
  assign stat_rd = rd_en && addr == STAT_ADDR;
  assign exp_par = odd_par_r ? ~^shift : ^shift;
  // STOP2 completion also needs the first stop sample to have been high
  assign stop_ok  = rx_s && !(state == STOP2 && stop_bad);
  assign frame_ok = done && stop_ok;
  assign push     = frame_ok && (!full || pop);

  always_comb begin
    state_nx  = state;
    frm_start = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop1_smp = 1'b0;
    done      = 1'b0;
    if (!rx_en_r) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: if (baud_div != '0 && !rx_s) begin
          state_nx  = START;
          frm_start = 1'b1;
        end
        START: if (half_eq) state_nx = rx_s ? IDLE : DATA;
        DATA: if (baud_eq) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nx = PARITY;
        end
        PARITY: if (baud_eq) begin
          par_chk  = 1'b1;
          state_nx = STOP1;
        end
        STOP1: if (baud_eq) begin
          stop1_smp = 1'b1;
          if (two_stop_r) state_nx = STOP2;
          else begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
        STOP2: if (baud_eq) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_div   <= '0;
      rx_en_r    <= 1'b0;
      two_stop_r <= 1'b0;
      odd_par_r  <= 1'b0;
    end else if (wr_en) begin
      if (addr == BAUD_ADDR) baud_div <= wr_data[13:0];
      if (addr == CTRL_ADDR) begin
        rx_en_r    <= wr_data[0];
        two_stop_r <= wr_data[1];
        odd_par_r  <= wr_data[2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      pe_pending <= 1'b0;
      stop_bad   <= 1'b0;
    end else begin
      cnt <= (state_nx != state || baud_eq) ? '0 : cnt + 14'd1;
      if (frm_start) begin
        bit_idx    <= '0;
        pe_pending <= 1'b0;
        stop_bad   <= 1'b0;
      end
      if (shift_en) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (par_chk && rx_s != exp_par) pe_pending <= 1'b1;
      if (stop1_smp && !rx_s) stop_bad <= 1'b1;
    end
  end

  // a flag raised this cycle wins over a status-read clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (done && !stop_ok) | (frame_err & ~stat_rd);
      parity_err <= (frame_ok && pe_pending) | (parity_err & ~stat_rd);
      overrun    <= (frame_ok && full && !pop) | (overrun & ~stat_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      unique case (1'b1)
        addr == DATA_ADDR: rd_data = empty ? '0 : {24'b0, mem[rd_ptr]};
        addr == BAUD_ADDR: rd_data = {18'b0, baud_div};
        addr == CTRL_ADDR: rd_data = {29'b0, odd_par_r, two_stop_r, rx_en_r};
        addr == STAT_ADDR:
          rd_data = {23'b0, frame_err, parity_err, overrun, full, empty, cnt4};
        default: rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// Frames are driven bit by bit at 10 clocks per bit (divisor 9).
module tb_uart_rx;

  localparam logic [31:0] DATA_A = 32'h10;
  localparam logic [31:0] BAUD_A = 32'h14;
  localparam logic [31:0] CTRL_A = 32'h18;
  localparam logic [31:0] STAT_A = 32'h1C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        Rx_in = 1'b1;
  logic        rx_valid;

  int n_vec = 0;
  int n_err = 0;

  uart_rx dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_data(wr_data),
    .wr_en(wr_en), .rd_en(rd_en), .rd_data(rd_data),
    .Rx_in(Rx_in), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    #1 d = rd_data;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // bits[0]=start, [8:1]=data, [9]=parity, [10]=stop1, [11]=stop2
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s1, input logic s2, input int nstop,
                            input int pop_at, output logic [31:0] popped);
    logic [11:0] bits;
    int nbits;
    bits = {s2, s1, p, d, 1'b0};
    nbits = 10 + nstop;
    popped = '0;
    for (int i = 0; i < nbits * 10; i++) begin
      @(negedge clk);
      Rx_in = bits[i / 10];
      if (i == pop_at) begin
        addr = DATA_A; rd_en = 1'b1;
        #1 popped = rd_data;
      end else begin
        rd_en = 1'b0;
      end
    end
    @(negedge clk);
    Rx_in = 1'b1; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #1;
    n_vec++;
    if (rx_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_rx_valid got %0b want 0", rx_valid);
    end
    n_vec++;
    if (rd_data !== 32'h0) begin
      n_err++; $display("FAIL reset_rd_data got %h want 0", rd_data);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h10) begin
      n_err++; $display("FAIL reset_status got %h want 10", v);
    end
    bus_read(BAUD_A, v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++; $display("FAIL reset_baud got %h want 0", v);
    end
  endtask

  task automatic test_basic();
    logic [31:0] v, pp;
    bus_write(BAUD_A, 32'd9);
    bus_write(CTRL_A, 32'h1);
    bus_read(BAUD_A, v);
    n_vec++;
    if (v !== 32'd9) begin
      n_err++; $display("FAIL baud_rb got %h want 9", v);
    end
    bus_read(CTRL_A, v);
    n_vec++;
    if (v !== 32'h1) begin
      n_err++; $display("FAIL ctrl_rb got %h want 1", v);
    end
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1, -1, pp);
    n_vec++;
    if (rx_valid !== 1'b1) begin
      n_err++; $display("FAIL basic_valid got %0b want 1", rx_valid);
    end
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h01) begin
      n_err++; $display("FAIL basic_stat got %h want 01", v);
    end
    bus_read(DATA_A, v);
    n_vec++;
    if (v !== 32'hA5) begin
      n_err++; $display("FAIL basic_data got %h want a5", v);
    end
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h10) begin
      n_err++; $display("FAIL basic_empty got %h want 10", v);
    end
  endtask

  task automatic test_parity_odd();
    logic [31:0] v, pp;
    bus_write(CTRL_A, 32'h7);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 2, -1, pp);
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h01) begin
      n_err++; $display("FAIL odd_ok_stat got %h want 01", v);
    end
    bus_read(DATA_A, v);
    n_vec++;
    if (v !== 32'h3C) begin
      n_err++; $display("FAIL odd_ok_data got %h want 3c", v);
    end
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 2, -1, pp);
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h81) begin
      n_err++; $display("FAIL odd_pe_stat got %h want 81", v);
    end
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h01) begin
      n_err++; $display("FAIL odd_pe_clear got %h want 01", v);
    end
    bus_read(DATA_A, v);
    n_vec++;
    if (v !== 32'h3C) begin
      n_err++; $display("FAIL odd_pe_data got %h want 3c", v);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] b [9];
    logic [31:0] v, pp;
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    bus_write(CTRL_A, 32'h1);
    for (int i = 0; i < 9; i++)
      send_frame(b[i], ^b[i], 1'b1, 1'b1, 1, -1, pp);
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h68) begin
      n_err++; $display("FAIL ovr_stat got %h want 68", v);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(DATA_A, v);
      n_vec++;
      if (v !== {24'b0, b[i]}) begin
        n_err++; $display("FAIL ovr_data%0d got %h want %h", i, v, b[i]);
      end
    end
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h10) begin
      n_err++; $display("FAIL ovr_drained got %h want 10", v);
    end
  endtask

  task automatic test_errors();
    logic [31:0] v, pp;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1, -1, pp);
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h110) begin
      n_err++; $display("FAIL ferr_stat got %h want 110", v);
    end
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h10) begin
      n_err++; $display("FAIL ferr_clear got %h want 10", v);
    end
    @(negedge clk); Rx_in = 1'b0;
    repeat (3) @(negedge clk);
    Rx_in = 1'b1;
    repeat (130) @(negedge clk);
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h10) begin
      n_err++; $display("FAIL glitch_stat got %h want 10", v);
    end
  endtask

  task automatic test_pop_on_full();
    logic [31:0] v, pp;
    for (int i = 1; i <= 8; i++)
      send_frame(8'(i), ^(8'(i)), 1'b1, 1'b1, 1, -1, pp);
    send_frame(8'h09, ^(8'h09), 1'b1, 1'b1, 1, 105, pp);
    n_vec++;
    if (pp !== 32'h01) begin
      n_err++; $display("FAIL pof_pop got %h want 01", pp);
    end
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h28) begin
      n_err++; $display("FAIL pof_stat got %h want 28", v);
    end
    for (int i = 2; i <= 9; i++) begin
      bus_read(DATA_A, v);
      n_vec++;
      if (v !== 32'(i)) begin
        n_err++; $display("FAIL pof_data%0d got %h want %h", i, v, i);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v, pp;
    logic [11:0] bits;
    send_frame(8'h5A, ^(8'h5A), 1'b1, 1'b1, 1, -1, pp);
    bits = {2'b11, ^(8'hC3), 8'hC3, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      Rx_in = bits[i / 10];
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if (rx_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_valid got %0b want 0", rx_valid);
    end
    n_vec++;
    if (rd_data !== 32'h0) begin
      n_err++; $display("FAIL rst_mid_rd got %h want 0", rd_data);
    end
    addr = STAT_A; rd_en = 1'b1;
    #1;
    n_vec++;
    if (rd_data !== 32'h10) begin
      n_err++; $display("FAIL rst_mid_stat got %h want 10", rd_data);
    end
    rd_en = 1'b0;
    Rx_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus_write(BAUD_A, 32'd9);
    bus_write(CTRL_A, 32'h1);
    send_frame(8'h96, ^(8'h96), 1'b1, 1'b1, 1, -1, pp);
    bus_read(DATA_A, v);
    n_vec++;
    if (v !== 32'h96) begin
      n_err++; $display("FAIL rst_mid_data got %h want 96", v);
    end
    bus_read(STAT_A, v);
    n_vec++;
    if (v !== 32'h10) begin
      n_err++; $display("FAIL rst_mid_end got %h want 10", v);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_odd();
    test_overrun();
    test_errors();
    test_pop_on_full();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
